// File: rtl/mul_pkg.sv
// mul_pkg: shared defaults and metadata/result types for the multiplier writeback stage
package mul_pkg;
  localparam int MUL_LATENCY = 3;
  localparam int MUL_TAG_W = 6;
  localparam int MUL_WB_W = MUL_TAG_W + 32;
  typedef struct packed {
    logic v;
    logic [MUL_TAG_W-1:0] tag;
    logic hi;
  } mul_meta_t;
  typedef struct packed {
    logic [MUL_TAG_W-1:0] tag;
    logic [31:0] data;
  } mul_wb_t;
endpackage

// File: rtl/mul_writeback_stage_fifo.sv
// mul_result_fifo: DEPTH-entry circular buffer of writeback results; storage itself is never reset
module mul_result_fifo
  import mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_push,
  input  logic [MUL_WB_W-1:0]     i_din,
  input  logic                    i_pop,
  output logic [MUL_WB_W-1:0]     o_head,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  mul_wb_t r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0] r_count;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  always_ff @(posedge i_clk)
    if (i_push && !i_flush) r_mem[r_wr] <= mul_wb_t'(i_din);
  assign o_head = r_mem[r_rd];
  assign o_count = r_count;
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && !i_flush && r_count == FULL));
endmodule

// File: rtl/mul_writeback_stage.sv
// mul_writeback_stage: tracks ops through the fixed-latency multiplier, captures and buffers the selected word.
// Define MUL_WRITEBACK_BYPASS_EN to present a capture combinationally when the result FIFO is empty.
module mul_writeback_stage
  import mul_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY,
  parameter int TAG_W = MUL_TAG_W,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_issue_valid,
  output logic             o_issue_ready,
  input  logic [TAG_W-1:0] i_issue_tag,
  input  logic             i_issue_hi,
  input  logic [63:0]      i_mul_product,
  output logic             o_wb_valid,
  input  logic             i_wb_ready,
  output logic [TAG_W-1:0] o_wb_tag,
  output logic [31:0]      o_wb_data,
  output logic [2:0]       o_inflight_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  mul_meta_t r_pipe [LATENCY];
  logic [2:0] r_inflight;
  logic [CW-1:0] w_count;
  mul_wb_t w_head;
  mul_wb_t w_cap;
  logic w_fire;
  logic w_capture;
  logic w_push;
  logic w_pop;
  logic w_empty;
  // credit: every op inside the array or the FIFO owns a FIFO slot
  assign o_issue_ready = (int'(w_count) + int'(r_inflight) < DEPTH) && !i_flush;
  assign w_fire = i_issue_valid && o_issue_ready;
  assign w_capture = r_pipe[LATENCY-1].v && !i_flush;
  assign w_cap = '{tag: r_pipe[LATENCY-1].tag,
                   data: r_pipe[LATENCY-1].hi ? i_mul_product[63:32] : i_mul_product[31:0]};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int k = 0; k < LATENCY; k++) r_pipe[k] <= '0;
      r_inflight <= '0;
    end else begin
      r_pipe[0] <= '{v: w_fire, tag: i_issue_tag, hi: i_issue_hi};
      for (int k = 1; k < LATENCY; k++) begin
        r_pipe[k] <= r_pipe[k-1];
        r_pipe[k].v <= r_pipe[k-1].v && !i_flush;
      end
      r_inflight <= i_flush ? '0 : r_inflight + 3'(w_fire) - 3'(w_capture);
    end
  assign o_inflight_cnt = r_inflight;
  assign w_empty = (w_count == '0);
  assign w_pop = !w_empty && i_wb_ready;
`ifdef MUL_WRITEBACK_BYPASS_EN
  logic w_bypass;
  assign w_bypass = w_empty && w_capture;
  assign w_push = w_capture && !(w_bypass && i_wb_ready);
  assign o_wb_valid = !w_empty || w_bypass;
  assign o_wb_tag = !w_empty ? w_head.tag : w_bypass ? w_cap.tag : '0;
  assign o_wb_data = !w_empty ? w_head.data : w_bypass ? w_cap.data : '0;
`else
  assign w_push = w_capture;
  assign o_wb_valid = !w_empty;
  assign o_wb_tag = w_empty ? '0 : w_head.tag;
  assign o_wb_data = w_empty ? '0 : w_head.data;
`endif
  mul_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_push  (w_push),
    .i_din   (w_cap),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_mul_writeback_stage.sv
// tb_mul_writeback_stage: scoreboard bench with a behavioural multiplier array and a queue-based reference model
`timescale 1ns/1ps
module tb_mul_writeback_stage;
  localparam int L = 3;
  localparam int TW = 6;
  localparam int DEPTH = 4;
`ifdef MUL_WRITEBACK_BYPASS_EN
  localparam int LAT_WB = L;
`else
  localparam int LAT_WB = L + 1;
`endif
  logic clk = 0;
  logic rst_n = 0;
  logic flush = 0;
  logic issue_valid = 0;
  logic issue_hi = 0;
  logic wb_ready = 0;
  logic [TW-1:0] issue_tag = 0;
  logic [31:0] op_a = 0;
  logic [31:0] op_b = 0;
  logic op_sgn = 0;
  logic issue_ready;
  logic wb_valid;
  logic [TW-1:0] wb_tag;
  logic [31:0] wb_data;
  logic [2:0] inflight_cnt;
  logic [63:0] mul_product;
  logic [63:0] arr [L];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0] data;
    int iss;
  } exp_t;
  exp_t q[$];
  int hist[$];
  bit popped = 0;

  mul_writeback_stage #(.LATENCY(L), .TAG_W(TW), .DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_issue_valid  (issue_valid),
    .o_issue_ready  (issue_ready),
    .i_issue_tag    (issue_tag),
    .i_issue_hi     (issue_hi),
    .i_mul_product  (mul_product),
    .o_wb_valid     (wb_valid),
    .i_wb_ready     (wb_ready),
    .o_wb_tag       (wb_tag),
    .o_wb_data      (wb_data),
    .o_inflight_cnt (inflight_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // multiplier array: computes whatever operands are driven, product appears L cycles later
  always @(posedge clk) begin
    arr[0] <= (op_sgn ? {{32{op_a[31]}}, op_a} : {32'd0, op_a}) * (op_sgn ? {{32{op_b[31]}}, op_b} : {32'd0, op_b});
    for (int k = 1; k < L; k++) arr[k] <= arr[k-1];
  end
  assign mul_product = arr[L-1];

  function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b, input logic s, input logic hi);
    longint p;
    p = s ? longint'($signed(a)) * longint'($signed(b)) : longint'({32'd0, a}) * longint'({32'd0, b});
    return hi ? p[63:32] : p[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // monitor: results become visible LAT_WB cycles after issue, in issue order
  always @(negedge clk) begin
    bit ev;
    popped = 0;
    ev = rst_n && q.size() > 0 && (q[0].iss + (flush ? L + 1 : LAT_WB) <= cyc);
    chk("wb_valid", 64'(wb_valid), 64'(ev));
    if (!wb_valid) begin
      chk("idle_wb_tag", 64'(wb_tag), 64'd0);
      chk("idle_wb_data", 64'(wb_data), 64'd0);
    end else if (ev && wb_ready) begin
      chk("wb_tag", 64'(wb_tag), 64'(q[0].tag));
      chk("wb_data", 64'(wb_data), 64'(q[0].data));
      void'(q.pop_front());
      popped = 1;
    end
  end

  // issue tracker: credit and in-flight expectations, then records this cycle's issue
  always @(negedge clk) begin
    int n;
    bit er;
    #1;
    if (!rst_n) begin
      q.delete();
      hist.delete();
    end else begin
      n = q.size() + int'(popped);
      er = (n < DEPTH) && !flush;
      chk("issue_ready", 64'(issue_ready), 64'(er));
      while (hist.size() > 0 && hist[0] < cyc - L) void'(hist.pop_front());
      chk("inflight_cnt", 64'(inflight_cnt), 64'(hist.size()));
      if (flush) begin
        q.delete();
        hist.delete();
      end else if (issue_valid && er) begin
        q.push_back('{tag: issue_tag, data: ref_word(op_a, op_b, op_sgn, issue_hi), iss: cyc});
        hist.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [TW-1:0] t, input logic h, input logic [31:0] a, input logic [31:0] b, input logic s);
    issue_valid = v;
    issue_tag = t;
    issue_hi = h;
    op_a = a;
    op_b = b;
    op_sgn = s;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic issue_one(input logic [TW-1:0] t, input logic h, input logic [31:0] a, input logic [31:0] b, input logic s);
    int n;
    bit acc;
    n = 0;
    drive(1, t, h, a, b, s);
    do begin
      @(negedge clk);
      acc = issue_ready && !flush;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("issue_accept", 64'(acc), 64'd1);
    issue_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    wb_ready = 1;
    repeat (3) tick();
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_wb_tag", 64'(wb_tag), 64'd0);
    chk("reset_wb_data", 64'(wb_data), 64'd0);
    chk("reset_inflight", 64'(inflight_cnt), 64'd0);
    #1 rst_n = 1;
    tick();
    issue_one(5, 0, 27, 31, 0);
    idle(8);
    issue_one(9, 1, 32'hFFFF_FFFF, 32'h2, 1);
    issue_one(9, 0, 32'hFFFF_FFFF, 32'h2, 1);
    idle(8);
    wb_ready = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, TW'(16 + i), 1'($urandom), $urandom, $urandom, 1'($urandom));
      tick();
    end
    idle(3);
    wb_ready = 1;
    idle(8);
    for (int i = 0; i < 16; i++) issue_one(TW'(i), 1'($urandom), $urandom, $urandom, 1'($urandom));
    idle(8);
    issue_one(40, 0, 7, 9, 0);
    issue_one(41, 1, 32'h8000_0000, 32'h8000_0000, 1);
    drive(1, 42, 0, 3, 3, 0);
    flush = 1;
    tick();
    flush = 0;
    idle(8);
    issue_one(43, 0, 1000, 1000, 0);
    idle(8);
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 9) < 7), TW'($urandom), 1'($urandom), $urandom, $urandom, 1'($urandom));
      wb_ready = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 31) == 0;
      tick();
    end
    flush = 0;
    wb_ready = 1;
    idle(12);
    wb_ready = 0;
    issue_one(50, 0, 11, 13, 0);
    issue_one(51, 1, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    idle(L + 2);
    #2 rst_n = 0;
    #1;
    chk("async_reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("async_reset_wb_data", 64'(wb_data), 64'd0);
    chk("async_reset_inflight", 64'(inflight_cnt), 64'd0);
    tick();
    tick();
    #1 rst_n = 1;
    wb_ready = 1;
    idle(8);
    issue_one(52, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    idle(8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
